atahost_pio_sched: RTL and testbench

Scheduler in front of the PIO timing controller. It shares the controller between two requesters: r0 for the command/control register port and r1 for the PIO data port. Arbitration is round-robin. For each granted access the block selects the timing set, holds address and write data on the ATA bus, and issues a one-cycle go. It captures read data on the data strobe, returns ack, and aborts stalled IORDY cycles with a watchdog.

---
 rtl/atahost_pio_sched.sv | 213 +++++++++++++++++++++
 tb/tb_atahost_pio_sched.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atahost_pio_sched.sv
// atahost_pio_sched: shares one PIO timing controller between the command/control
// register port (r0) and the PIO data port (r1). Grants are round-robin. Each granted
// access latches the timing set, address and write data, issues a one-cycle go, and
// captures read data on the data strobe. A watchdog aborts cycles stalled on IORDY.
// All outputs come straight from flops.

module atahost_pio_sched #(
  parameter int unsigned TWIDTH  = 8,
  parameter int unsigned TOWIDTH = 16
) (
  input  logic                clk,
  input  logic                nReset,

  // timing sets, packed {T1,T2,T4,Teoc}, MSB first
  input  logic [4*TWIDTH-1:0] tim_cmd,
  input  logic [4*TWIDTH-1:0] tim_dev0,
  input  logic [4*TWIDTH-1:0] tim_dev1,
  input  logic [TOWIDTH-1:0]  tout,

  // requester 0: command/control register port
  input  logic                r0_req,
  input  logic                r0_we,
  input  logic [3:0]          r0_adr,
  input  logic [15:0]         r0_dat,
  output logic                r0_ack,

  // requester 1: PIO data port
  input  logic                r1_req,
  input  logic                r1_we,
  input  logic                r1_dev,
  input  logic [3:0]          r1_adr,
  input  logic [15:0]         r1_dat,
  output logic                r1_ack,

  output logic                err,
  output logic [15:0]         q,

  // timing controller interface
  output logic                pio_go,
  output logic                pio_we,
  output logic [TWIDTH-1:0]   pio_T1,
  output logic [TWIDTH-1:0]   pio_T2,
  output logic [TWIDTH-1:0]   pio_T4,
  output logic [TWIDTH-1:0]   pio_Teoc,
  output logic                pio_rst,
  input  logic                pio_done,
  input  logic                pio_dstrb,

  // ATA bus
  output logic [3:0]          ata_adr,
  output logic [15:0]         ata_dd_o,
  input  logic [15:0]         ata_dd_i
);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StAck,
    StAbort
  } state_e;

  state_e              state_q, state_d;

  // 1 = r1 was granted last (also identifies the owner of the access in flight)
  logic                last_q, last_d;

  logic [TOWIDTH-1:0]  cnt_q, cnt_d;
  logic [4*TWIDTH-1:0] tim_q, tim_d;
  logic [3:0]          adr_q, adr_d;
  logic [15:0]         dd_q, dd_d;
  logic                we_q, we_d;
  logic                go_q, go_d;
  logic                rst_q, rst_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic                err_q, err_d;
  logic [15:0]         rdat_q, rdat_d;

  logic                pick_r1;
  logic                wd_enable;
  logic                wd_expired;
  logic [TOWIDTH-1:0]  wd_limit;

  // r1 wins when it is alone, or when both ask and r0 was served last
  assign pick_r1    = r1_req & (~r0_req | ~last_q);

  assign wd_limit   = tout - TOWIDTH'(1);
  assign wd_enable  = (tout != '0);
  assign wd_expired = wd_enable & (cnt_q == wd_limit);

  // Next-state and next-output logic; every output register is rebuilt here
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tim_d   = tim_q;
    adr_d   = adr_q;
    dd_d    = dd_q;
    we_d    = we_q;
    rdat_d  = rdat_q;
    go_d    = 1'b0;
    rst_d   = 1'b0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (r0_req || r1_req) begin
          state_d = StIssue;
          last_d  = pick_r1;
          go_d    = 1'b1;
          if (pick_r1) begin
            adr_d = r1_adr;
            dd_d  = r1_dat;
            we_d  = r1_we;
            tim_d = r1_dev ? tim_dev1 : tim_dev0;
          end else begin
            adr_d = r0_adr;
            dd_d  = r0_dat;
            we_d  = r0_we;
            tim_d = tim_cmd;
          end
        end
      end

      StIssue: begin
        state_d = StWait;
        cnt_d   = '0;
      end

      StWait: begin
        if (pio_dstrb && !we_q) begin
          rdat_d = ata_dd_i;
        end
        // done outranks the watchdog when both land on the same edge
        if (pio_done) begin
          state_d = StAck;
          ack0_d  = ~last_q;
          ack1_d  = last_q;
        end else if (wd_expired) begin
          state_d = StAbort;
          rst_d   = 1'b1;
          ack0_d  = ~last_q;
          ack1_d  = last_q;
          err_d   = 1'b1;
          // an aborted cycle never updates the read data
          rdat_d  = rdat_q;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + TOWIDTH'(1);
        end
      end

      StAck, StAbort: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nReset) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      tim_q   <= '0;
      adr_q   <= '0;
      dd_q    <= '0;
      we_q    <= 1'b0;
      rdat_q  <= '0;
      go_q    <= 1'b0;
      rst_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tim_q   <= tim_d;
      adr_q   <= adr_d;
      dd_q    <= dd_d;
      we_q    <= we_d;
      rdat_q  <= rdat_d;
      go_q    <= go_d;
      rst_q   <= rst_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err_q   <= err_d;
    end
  end

  assign r0_ack   = ack0_q;
  assign r1_ack   = ack1_q;
  assign err      = err_q;
  assign q        = rdat_q;
  assign pio_go   = go_q;
  assign pio_we   = we_q;
  assign pio_rst  = rst_q;
  assign ata_adr  = adr_q;
  assign ata_dd_o = dd_q;

  assign pio_T1   = tim_q[4*TWIDTH-1 -: TWIDTH];
  assign pio_T2   = tim_q[3*TWIDTH-1 -: TWIDTH];
  assign pio_T4   = tim_q[2*TWIDTH-1 -: TWIDTH];
  assign pio_Teoc = tim_q[TWIDTH-1 -: TWIDTH];

endmodule

// File: tb/tb_atahost_pio_sched.sv
// Bench for atahost_pio_sched: a behavioural timing controller answers each go,
// requester tasks drive r0/r1, and a scoreboard of expected completions is checked
// whenever an ack appears.

module tb_atahost_pio_sched;

  localparam int unsigned TW  = 8;
  localparam int unsigned TOW = 16;

  logic          clk = 1'b0;
  logic          nReset;
  logic [4*TW-1:0] tim_cmd, tim_dev0, tim_dev1;
  logic [TOW-1:0]  tout;
  logic          r0_req, r0_we, r0_ack;
  logic [3:0]    r0_adr;
  logic [15:0]   r0_dat;
  logic          r1_req, r1_we, r1_dev, r1_ack;
  logic [3:0]    r1_adr;
  logic [15:0]   r1_dat;
  logic          err;
  logic [15:0]   q;
  logic          pio_go, pio_we, pio_rst, pio_done, pio_dstrb;
  logic [TW-1:0] pio_T1, pio_T2, pio_T4, pio_Teoc;
  logic [3:0]    ata_adr;
  logic [15:0]   ata_dd_o, ata_dd_i;

  typedef struct {
    bit          port;
    logic        err;
    logic [15:0] q;
    logic [3:0]  adr;
    logic [15:0] dat;
    logic        we;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int go_count = 0;
  bit go_prev  = 1'b0;
  bit ctl_hang = 1'b0;
  int ctl_lat  = 2;

  always #5 clk = ~clk;

  atahost_pio_sched #(.TWIDTH(TW), .TOWIDTH(TOW)) dut (
    .clk       (clk),
    .nReset    (nReset),
    .tim_cmd   (tim_cmd),
    .tim_dev0  (tim_dev0),
    .tim_dev1  (tim_dev1),
    .tout      (tout),
    .r0_req    (r0_req),
    .r0_we     (r0_we),
    .r0_adr    (r0_adr),
    .r0_dat    (r0_dat),
    .r0_ack    (r0_ack),
    .r1_req    (r1_req),
    .r1_we     (r1_we),
    .r1_dev    (r1_dev),
    .r1_adr    (r1_adr),
    .r1_dat    (r1_dat),
    .r1_ack    (r1_ack),
    .err       (err),
    .q         (q),
    .pio_go    (pio_go),
    .pio_we    (pio_we),
    .pio_T1    (pio_T1),
    .pio_T2    (pio_T2),
    .pio_T4    (pio_T4),
    .pio_Teoc  (pio_Teoc),
    .pio_rst   (pio_rst),
    .pio_done  (pio_done),
    .pio_dstrb (pio_dstrb),
    .ata_adr   (ata_adr),
    .ata_dd_o  (ata_dd_o),
    .ata_dd_i  (ata_dd_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit port, input logic e, input logic [15:0] qv,
                      input logic [3:0] adr, input logic [15:0] dat, input logic we);
    exp_t x;
    x.port = port;
    x.err  = e;
    x.q    = qv;
    x.adr  = adr;
    x.dat  = dat;
    x.we   = we;
    sb.push_back(x);
  endtask

  task automatic wait_go(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (pio_go) seen = 1'b1;
    end
  endtask

  // Drive one access on a requester and hold it until its ack (bounded)
  task automatic access(input bit port, input logic we, input logic dev,
                        input logic [3:0] adr, input logic [15:0] dat);
    bit got;
    got = 1'b0;
    if (!port) begin
      r0_we = we; r0_adr = adr; r0_dat = dat; r0_req = 1'b1;
    end else begin
      r1_we = we; r1_dev = dev; r1_adr = adr; r1_dat = dat; r1_req = 1'b1;
    end
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (port ? r1_ack : r0_ack) got = 1'b1;
    end
    check(port ? "r1_ack_seen" : "r0_ack_seen", 32'(got), 1);
    if (!port) r0_req = 1'b0;
    else       r1_req = 1'b0;
  endtask

  // Behavioural timing controller: done and dstrb together, ctl_lat cycles after go
  initial begin
    pio_done  = 1'b0;
    pio_dstrb = 1'b0;
    forever begin
      @(negedge clk);
      pio_done  = 1'b0;
      pio_dstrb = 1'b0;
      if (pio_go && !ctl_hang) begin
        repeat (ctl_lat) @(negedge clk);
        pio_done  = 1'b1;
        pio_dstrb = 1'b1;
      end
    end
  end

  // Scoreboard: every ack must match the next expected completion
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (r0_ack || r1_ack) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", 32'({r0_ack, r1_ack}), 0);
        end else begin
          e = sb.pop_front();
          check("ack_port", 32'(r1_ack), 32'(e.port));
          check("ack_exclusive", 32'(r0_ack & r1_ack), 0);
          check("ack_err", 32'(err), 32'(e.err));
          check("ack_q", 32'(q), 32'(e.q));
          check("ack_adr", 32'(ata_adr), 32'(e.adr));
          check("ack_dd_o", 32'(ata_dd_o), 32'(e.dat));
          check("ack_we", 32'(pio_we), 32'(e.we));
        end
      end
    end
  end

  // go must be a single-cycle strobe
  initial begin
    forever begin
      @(negedge clk);
      if (pio_go) begin
        go_count++;
        check("go_one_cycle", 32'({go_prev, pio_go}), 'b01);
      end
      go_prev = pio_go;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit seen;
    int ack_cnt;

    nReset   = 1'b0;
    tim_cmd  = {8'd2, 8'd2, 8'd2, 8'd2};
    tim_dev0 = {8'd1, 8'd1, 8'd1, 8'd1};
    tim_dev1 = {8'd7, 8'd7, 8'd7, 8'd7};
    tout     = '0;
    r0_req = 1'b0; r0_we = 1'b0; r0_adr = '0; r0_dat = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_dev = 1'b0; r1_adr = '0; r1_dat = '0;
    ata_dd_i = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_r0_ack", 32'(r0_ack), 0);
    check("rst_r1_ack", 32'(r1_ack), 0);
    check("rst_err", 32'(err), 0);
    check("rst_q", 32'(q), 0);
    check("rst_go", 32'(pio_go), 0);
    check("rst_pio_rst", 32'(pio_rst), 0);
    check("rst_we", 32'(pio_we), 0);
    check("rst_adr", 32'(ata_adr), 0);
    check("rst_dd_o", 32'(ata_dd_o), 0);
    check("rst_T1", 32'(pio_T1), 0);
    check("rst_Teoc", 32'(pio_Teoc), 0);
    nReset = 1'b1;

    // Both requesters continuously busy: r0 first, then strict alternation
    for (int i = 0; i < 3; i++) begin
      push(1'b0, 1'b0, 16'h0000, 4'(i + 1), 16'h1000 + 16'(i), 1'b1);
      push(1'b1, 1'b0, 16'h0000, 4'(i + 8), 16'h2000 + 16'(i), 1'b1);
    end
    fork
      begin
        for (int i = 0; i < 3; i++) access(1'b0, 1'b1, 1'b0, 4'(i + 1), 16'h1000 + 16'(i));
      end
      begin
        for (int j = 0; j < 3; j++) access(1'b1, 1'b1, 1'b0, 4'(j + 8), 16'h2000 + 16'(j));
      end
    join
    check("alt_go_count", 32'(go_count), 6);

    // r1 read from device 1
    tim_dev0 = {8'd9, 8'd9, 8'd9, 8'd9};
    tim_dev1 = {8'd3, 8'd5, 8'd1, 8'd4};
    ata_dd_i = 16'hA55A;
    push(1'b1, 1'b0, 16'hA55A, 4'h8, 16'hBEEF, 1'b0);
    fork
      access(1'b1, 1'b0, 1'b1, 4'h8, 16'hBEEF);
      begin
        wait_go(seen);
        check("rd_go_seen", 32'(seen), 1);
        check("rd_T1", 32'(pio_T1), 3);
        check("rd_T2", 32'(pio_T2), 5);
        check("rd_T4", 32'(pio_T4), 1);
        check("rd_Teoc", 32'(pio_Teoc), 4);
        check("rd_we", 32'(pio_we), 0);
      end
    join
    @(negedge clk);
    check("rd_ack_one_cycle", 32'(r1_ack), 0);
    check("rd_err_clear", 32'(err), 0);

    // r0 write: bus holds after the cycle, strobe on a write leaves q alone
    ata_dd_i = 16'h5555;
    push(1'b0, 1'b0, 16'hA55A, 4'hE, 16'h1234, 1'b1);
    access(1'b0, 1'b1, 1'b0, 4'hE, 16'h1234);
    repeat (3) @(negedge clk);
    check("wr_adr_hold", 32'(ata_adr), 'hE);
    check("wr_dd_hold", 32'(ata_dd_o), 'h1234);
    check("wr_q_kept", 32'(q), 'hA55A);

    // Watchdog abort with tout=10 and a controller that never finishes
    tout     = 16'd10;
    ctl_hang = 1'b1;
    push(1'b0, 1'b1, 16'hA55A, 4'h3, 16'h0000, 1'b0);
    fork
      access(1'b0, 1'b0, 1'b0, 4'h3, 16'h0000);
      begin
        wait_go(seen);
        check("wd_go_seen", 32'(seen), 1);
        for (int k = 1; k <= 12; k++) begin
          @(negedge clk);
          check($sformatf("wd_pio_rst_c%0d", k), 32'(pio_rst), 32'(k == 11));
          check($sformatf("wd_err_c%0d", k), 32'(err), 32'(k == 11));
        end
      end
    join

    // tout=0: wait indefinitely, then reset in WAIT abandons the access
    tout = '0;
    r1_we = 1'b1; r1_dev = 1'b0; r1_adr = 4'h9; r1_dat = 16'h7777; r1_req = 1'b1;
    wait_go(seen);
    check("nowd_go_seen", 32'(seen), 1);
    ack_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (r0_ack || r1_ack || pio_rst) ack_cnt++;
    end
    check("nowd_no_ack", 32'(ack_cnt), 0);
    nReset = 1'b0;
    r1_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("midrst_pio_rst", 32'(pio_rst), 0);
      check("midrst_r1_ack", 32'(r1_ack), 0);
      check("midrst_q", 32'(q), 0);
      check("midrst_adr", 32'(ata_adr), 0);
    end
    nReset = 1'b1;

    // Normal access after the reset, watchdog armed but not reached
    ctl_hang = 1'b0;
    tout     = 16'd10;
    tim_dev0 = {8'd4, 8'd3, 8'd2, 8'd1};
    push(1'b1, 1'b0, 16'h0000, 4'h5, 16'hC0DE, 1'b1);
    fork
      access(1'b1, 1'b1, 1'b0, 4'h5, 16'hC0DE);
      begin
        wait_go(seen);
        check("post_go_seen", 32'(seen), 1);
        check("post_T1", 32'(pio_T1), 4);
        check("post_Teoc", 32'(pio_Teoc), 1);
      end
    join

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
